seq_alu_muldiv: RTL and testbench

//  Parametrised successor to the combinational ALU: a registered ALU with iterative MULTU/DIVU.

---
 rtl/seq_alu_muldiv.sv | 184 ++++++++++++++++++
 tb/tb_seq_alu_muldiv.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_muldiv.sv
// Registered EX-stage ALU: logic/arith/shift/slt finish in one cycle, MULTU and DIVU
// iterate WIDTH shift-add / restoring steps and leave their result in HI/LO.
module seq_alu_muldiv #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_start,
  input  logic [3:0]         in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_busy,
  output logic               out_done,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_zero,
  output logic [WIDTH-1:0]   out_hi,
  output logic [WIDTH-1:0]   out_lo,
  output logic               out_div_by_zero,
  output logic [1:0]         out_dbg_state
);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_NOR   = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;
  localparam logic [3:0] OP_DIVU  = 4'd10;
  localparam int         CNT_W    = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;
  logic [WIDTH-1:0]     alu_res;

  // acc = {partial product, remaining multiplier}; one conditional add then shift right.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   mcand);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    return {sum, acc[WIDTH-1:1]};
  endfunction

  // acc = {remainder, dividend/quotient}; borrow in diff means restore (quotient bit 0).
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   divisor);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[WIDTH]) return {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  endfunction

  // Native shift operators already yield 0 / sign fill for amounts >= WIDTH.
  always_comb begin
    alu_res = '0;
    case (in_op)
      OP_AND: alu_res = in_a & in_b;
      OP_OR:  alu_res = in_a | in_b;
      OP_NOR: alu_res = ~(in_a | in_b);
      OP_ADD: alu_res = in_a + in_b;
      OP_SUB: alu_res = in_a - in_b;
      OP_SLL: alu_res = in_b << in_shamt;
      OP_SRL: alu_res = in_b >> in_shamt;
      OP_SRA: alu_res = $signed(in_b) >>> in_shamt;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      default: alu_res = '0;
    endcase
  end

  // The capture cycle performs the first iteration, so RUN covers the other WIDTH-1.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    result_d = result_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          dbz_d = 1'b0;
          if (in_op == OP_MULTU) begin
            is_div_d = 1'b0;
            opnd_d   = in_b;
            count_d  = '0;
            acc_d    = mul_step({{WIDTH{1'b0}}, in_a}, in_b);
            state_d  = S_RUN;
          end else if (in_op == OP_DIVU) begin
            is_div_d = 1'b1;
            opnd_d   = in_b;
            count_d  = '0;
            if (in_b == '0) begin
              acc_d   = {in_a, {WIDTH{1'b1}}};
              state_d = S_FIN;
            end else begin
              acc_d   = div_step({{WIDTH{1'b0}}, in_a}, in_b);
              state_d = S_RUN;
            end
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
          end
        end
      end
      S_RUN: begin
        acc_d   = is_div_q ? div_step(acc_q, opnd_q) : mul_step(acc_q, opnd_q);
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH-2)) state_d = S_FIN;
      end
      S_FIN: begin
        hi_d    = acc_q[2*WIDTH-1:WIDTH];
        lo_d    = acc_q[WIDTH-1:0];
        dbz_d   = is_div_q && (opnd_q == '0);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    out_busy        = (state_q == S_RUN);
    out_done        = done_q;
    out_result      = result_q;
    out_zero        = zero_q;
    out_hi          = hi_q;
    out_lo          = lo_q;
    out_div_by_zero = dbz_q;
    out_dbg_state   = state_q;
  end

endmodule

// File: tb/tb_seq_alu_muldiv.sv
// Bench for seq_alu_muldiv: transaction-level reference model checked every cycle,
// plus directed vectors with hand-computed literals.
module tb_seq_alu_muldiv;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_start;
  logic [3:0]    in_op;
  logic [W-1:0]  in_a, in_b;
  logic [4:0]    in_shamt;
  logic          out_busy, out_done, out_zero, out_div_by_zero;
  logic [W-1:0]  out_result, out_hi, out_lo;
  logic [1:0]    out_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  seq_alu_muldiv #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .in_start(in_start), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt),
    .out_busy(out_busy), .out_done(out_done), .out_result(out_result),
    .out_zero(out_zero), .out_hi(out_hi), .out_lo(out_lo),
    .out_div_by_zero(out_div_by_zero), .out_dbg_state(out_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [4:0] sh);
    logic [2*W-1:0] sext;
    sext = {{W{b[W-1]}}, b};
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return ~(a | b);
      4'd3: return a + b;
      4'd4: return a - b;
      4'd5: return (int'(sh) >= W) ? '0 : W'(64'(b) << sh);
      4'd6: return (int'(sh) >= W) ? '0 : W'(64'(b) >> sh);
      4'd7: return W'(sext >> sh);
      4'd8: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  int           m_pend;
  logic         m_done, m_zero, m_dbz, p_dbz;
  logic [W-1:0] m_result, m_hi, m_lo, p_hi, p_lo;

  // m_pend = cycles left until the long op's done pulse (latency WIDTH+1, or 2 for /0).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend <= 0; m_done <= 1'b0; m_result <= '0; m_zero <= 1'b1;
      m_hi <= '0; m_lo <= '0; m_dbz <= 1'b0;
      p_hi <= '0; p_lo <= '0; p_dbz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_pend != 0) begin
        m_pend <= m_pend - 1;
        if (m_pend == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_dbz <= p_dbz; m_done <= 1'b1;
        end
      end else if (in_start) begin
        m_dbz <= 1'b0;
        if (in_op == 4'd9) begin
          {p_hi, p_lo} <= 64'(in_a) * 64'(in_b);
          p_dbz <= 1'b0; m_pend <= W;
        end else if (in_op == 4'd10) begin
          if (in_b == '0) begin
            p_hi <= in_a; p_lo <= '1; p_dbz <= 1'b1; m_pend <= 1;
          end else begin
            p_hi <= in_a % in_b; p_lo <= in_a / in_b; p_dbz <= 1'b0; m_pend <= W;
          end
        end else begin
          m_result <= ref_alu(in_op, in_a, in_b, in_shamt);
          m_zero   <= (ref_alu(in_op, in_a, in_b, in_shamt) == '0);
          m_done   <= 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    wait (reset === 1'b1);
    forever begin
      @(negedge clk);
      check("cyc_busy",   W'(out_busy),        W'(m_pend >= 2));
      check("cyc_done",   W'(out_done),        W'(m_done));
      check("cyc_result", out_result,          m_result);
      check("cyc_zero",   W'(out_zero),        W'(m_zero));
      check("cyc_hi",     out_hi,              m_hi);
      check("cyc_lo",     out_lo,              m_lo);
      check("cyc_dbz",    W'(out_div_by_zero), W'(m_dbz));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh);
    in_op = op; in_a = a; in_b = b; in_shamt = sh; in_start = 1'b1;
    @(posedge clk); #1;
    in_start = 1'b0;
  endtask

  // Counts cycles from the start cycle (cycle 0) until out_done is seen.
  task automatic wait_done(input int from_cyc, output int cyc);
    cyc = from_cyc;
    while (out_done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (out_done !== 1'b1) check("done_timeout", W'(0), W'(1));
  endtask

  task automatic run_vec(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh, input logic [W-1:0] exp);
    issue(op, a, b, sh);
    check(name, out_result, exp);
    check({name, "_zero"}, W'(out_zero), W'(exp == '0));
    check({name, "_done"}, W'(out_done), W'(1));
  endtask

  // ---------------- directed stimulus ----------------
  int lat;
  int pulses;

  initial begin
    in_start = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_shamt = '0; reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_result", out_result, 32'h0);
    check("rst_zero",   W'(out_zero), W'(1));
    check("rst_hilo",   out_hi | out_lo, 32'h0);
    check("rst_busy",   W'(out_busy | out_done | out_div_by_zero), W'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    run_vec("add_wrap", 4'd3, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0);
    run_vec("sub",      4'd4, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE);
    run_vec("sra",      4'd7, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000);
    run_vec("sll31",    4'd5, 32'h0, 32'h1, 5'd31, 32'h8000_0000);
    run_vec("srl31",    4'd6, 32'h0, 32'h8000_0000, 5'd31, 32'h1);
    run_vec("or",       4'd1, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 32'hF0F0_0F0F);
    run_vec("and",      4'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 32'h0F00_0F00);
    run_vec("nor",      4'd2, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF);
    run_vec("slt_neg",  4'd8, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1);
    run_vec("slt_pos",  4'd8, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h0);
    run_vec("slt_eq",   4'd8, 32'd5, 32'd5, 5'd0, 32'h0);
    run_vec("sra_pos",  4'd7, 32'h0, 32'h7000_0000, 5'd4, 32'h0700_0000);
    run_vec("add_ovf",  4'd3, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000);
    run_vec("op_b",     4'hB, 32'd5, 32'd5, 5'd0, 32'h0);
    run_vec("op_f",     4'hF, 32'h1234, 32'h1, 5'd0, 32'h0);
    run_vec("add_3",    4'd3, 32'd1, 32'd2, 5'd0, 32'd3);

    issue(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    check("mul_busy", W'(out_busy), W'(1));
    wait_done(1, lat);
    check("mul_latency", W'(lat), W'(33));
    check("mul_hi", out_hi, 32'hFFFF_FFFE);
    check("mul_lo", out_lo, 32'h0000_0001);
    check("mul_keeps_result", out_result, 32'd3);

    issue(4'd3, 32'd10, 32'd20, 5'd0);
    check("hilo_held_hi", out_hi, 32'hFFFF_FFFE);
    check("hilo_held_lo", out_lo, 32'h0000_0001);

    issue(4'd9, 32'd1000, 32'd3000, 5'd0);
    repeat (3) begin @(posedge clk); #1; end
    in_op = 4'd3; in_a = 32'd7; in_b = 32'd7; in_start = 1'b1;
    @(posedge clk); #1;
    in_start = 1'b0;
    check("ignored_add", out_result, 32'd30);
    wait_done(5, lat);
    check("mul2_latency", W'(lat), W'(33));
    check("mul2_lo", out_lo, 32'h002D_C6C0);
    check("mul2_hi", out_hi, 32'h0);
    check("mul2_result", out_result, 32'd30);

    issue(4'd10, 32'd100, 32'd7, 5'd0);
    wait_done(1, lat);
    check("div_latency", W'(lat), W'(33));
    check("div_lo", out_lo, 32'd14);
    check("div_hi", out_hi, 32'd2);
    check("div_dbz", W'(out_div_by_zero), W'(0));
    issue(4'd9, 32'd7, 32'd6, 5'd0);
    check("start_on_done", W'(out_busy), W'(1));
    wait_done(1, lat);
    check("b2b_latency", W'(lat), W'(33));
    check("b2b_lo", out_lo, 32'd42);

    issue(4'd10, 32'd9, 32'd0, 5'd0);
    check("dz_not_busy", W'(out_busy), W'(0));
    wait_done(1, lat);
    check("dz_latency", W'(lat), W'(2));
    check("dz_hi", out_hi, 32'd9);
    check("dz_lo", out_lo, 32'hFFFF_FFFF);
    check("dz_flag", W'(out_div_by_zero), W'(1));
    issue(4'd3, 32'd0, 32'd0, 5'd0);
    check("dz_cleared", W'(out_div_by_zero), W'(0));
    check("dz_hi_held", out_hi, 32'd9);

    issue(4'd10, 32'd1000, 32'd3, 5'd0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", W'(out_busy), W'(0));
    check("abort_hilo", out_hi | out_lo, 32'h0);
    check("abort_zero", W'(out_zero), W'(1));
    @(posedge clk); #1;
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_done === 1'b1) pulses++;
    end
    check("abort_no_done", W'(pulses), W'(0));

    issue(4'd10, 32'hFFFF_FFFF, 32'h10, 5'd0);
    wait_done(1, lat);
    check("div2_lo", out_lo, 32'h0FFF_FFFF);
    check("div2_hi", out_hi, 32'h0000_000F);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
